// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_pkg : shared state encoding and constants for round_sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHOW    = 3'd1,
      ST_HIDE    = 3'd2,
      ST_SHUFFLE = 3'd3,
      ST_GUESS   = 3'd4,
      ST_RESULT  = 3'd5,
      ST_OVER    = 3'd6
   } state_t;

   localparam int         ZONE_W    = 2;
   localparam logic [3:0] SCORE_MAX = 4'd9;

   function automatic logic [3:0] score_inc(input logic [3:0] v);
      return (v >= SCORE_MAX) ? SCORE_MAX : v + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_timer : loadable down-counter stepped by frame_tick            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module frame_timer #(
   parameter int TMR_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             frame_tick,
   output logic             done
);

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   // Load wins over a same-cycle tick, so the entry-cycle tick is not counted.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (frame_tick && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   assign done = frame_tick && (count_q == TMR_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_sequencer : game-round FSM, zone selection, score and lives    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module round_sequencer
   import game_pkg::*;
#(
   parameter int SHOW_FRAMES    = 120,
   parameter int HIDE_FRAMES    = 30,
   parameter int SHUFFLE_FRAMES = 180,
   parameter int GUESS_FRAMES   = 600,
   parameter int RESULT_FRAMES  = 90,
   parameter int LIVES          = 3,
   parameter int TMR_W          = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              confirm_btn,
   input  logic              select_btn,
   input  logic [ZONE_W-1:0] target_zone,
   output logic [2:0]        state,
   output logic [ZONE_W-1:0] sel_zone,
   output logic              zone_latch,
   output logic              anim_en,
   output logic              hit,
   output logic [3:0]        score,
   output logic [1:0]        lives
);

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   // Button synchronizers and edge detectors
   logic [1:0] sync_vld_q, sync_vld_d;
   logic conf_s1_q, conf_s1_d, conf_s2_q, conf_s2_d;
   logic conf_prev_q, conf_prev_d, conf_edge_q, conf_edge_d;
   logic sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
   logic sel_prev_q, sel_prev_d, sel_edge_q, sel_edge_d;

   // History is forced high until the synchronizer holds real samples, so a
   // button held through reset release does not register as a press.
   always_comb begin
      sync_vld_d  = {sync_vld_q[0], 1'b1};
      conf_s1_d   = confirm_btn;
      conf_s2_d   = conf_s1_q;
      conf_prev_d = sync_vld_q[1] ? conf_s2_q : 1'b1;
      conf_edge_d = sync_vld_q[1] & conf_s2_q & ~conf_prev_q;
      sel_s1_d    = select_btn;
      sel_s2_d    = sel_s1_q;
      sel_prev_d  = sync_vld_q[1] ? sel_s2_q : 1'b1;
      sel_edge_d  = sync_vld_q[1] & sel_s2_q & ~sel_prev_q;
   end

   // Game state
   state_t            state_q, state_d;
   logic [ZONE_W-1:0] sel_zone_q, sel_zone_d;
   logic              zone_latch_q, zone_latch_d;
   logic              anim_en_q, anim_en_d;
   logic              hit_q, hit_d;
   logic [3:0]        score_q, score_d;
   logic [1:0]        lives_q, lives_d;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_done;
   logic              guess_ok;
   logic [1:0]        lives_dec;

   assign guess_ok  = (sel_zone_q == target_zone);
   assign lives_dec = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;

   always_comb begin
      state_d      = state_q;
      sel_zone_d   = sel_zone_q;
      zone_latch_d = 1'b0;
      hit_d        = hit_q;
      score_d      = score_q;
      lives_d      = lives_q;
      case (state_q)
         ST_IDLE: begin
            if (conf_edge_q) begin
               state_d      = ST_SHOW;
               zone_latch_d = 1'b1;
               score_d      = 4'd0;
               lives_d      = LIVES_INIT;
               sel_zone_d   = '0;
            end
         end
         ST_SHOW:    if (tmr_done) state_d = ST_HIDE;
         ST_HIDE:    if (tmr_done) state_d = ST_SHUFFLE;
         ST_SHUFFLE: if (tmr_done) state_d = ST_GUESS;
         ST_GUESS: begin
            // Confirm outranks both timeout and a same-cycle select.
            if (conf_edge_q) begin
               state_d = ST_RESULT;
               hit_d   = guess_ok;
               if (guess_ok) score_d = score_inc(score_q);
               else          lives_d = lives_dec;
            end else if (tmr_done) begin
               state_d = ST_RESULT;
               hit_d   = 1'b0;
               lives_d = lives_dec;
            end else if (sel_edge_q) begin
               sel_zone_d = sel_zone_q + 1'b1;
            end
         end
         ST_RESULT: begin
            if (tmr_done) begin
               if (lives_q == 2'd0) begin
                  state_d = ST_OVER;
               end else begin
                  state_d      = ST_SHOW;
                  zone_latch_d = 1'b1;
                  sel_zone_d   = '0;
               end
            end
         end
         ST_OVER:    if (conf_edge_q) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      anim_en_d = (state_d == ST_SHUFFLE);
      tmr_load  = (state_d != state_q);
      case (state_d)
         ST_SHOW:    tmr_val = TMR_W'(SHOW_FRAMES);
         ST_HIDE:    tmr_val = TMR_W'(HIDE_FRAMES);
         ST_SHUFFLE: tmr_val = TMR_W'(SHUFFLE_FRAMES);
         ST_GUESS:   tmr_val = TMR_W'(GUESS_FRAMES);
         ST_RESULT:  tmr_val = TMR_W'(RESULT_FRAMES);
         default:    tmr_val = '0;
      endcase
   end

   frame_timer #(
      .TMR_W (TMR_W)
   ) u_frame_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .frame_tick (frame_tick),
      .done       (tmr_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_vld_q   <= 2'b00;
         conf_s1_q    <= 1'b0;
         conf_s2_q    <= 1'b0;
         conf_prev_q  <= 1'b1;
         conf_edge_q  <= 1'b0;
         sel_s1_q     <= 1'b0;
         sel_s2_q     <= 1'b0;
         sel_prev_q   <= 1'b1;
         sel_edge_q   <= 1'b0;
         state_q      <= ST_IDLE;
         sel_zone_q   <= '0;
         zone_latch_q <= 1'b0;
         anim_en_q    <= 1'b0;
         hit_q        <= 1'b0;
         score_q      <= 4'd0;
         lives_q      <= LIVES_INIT;
      end else begin
         sync_vld_q   <= sync_vld_d;
         conf_s1_q    <= conf_s1_d;
         conf_s2_q    <= conf_s2_d;
         conf_prev_q  <= conf_prev_d;
         conf_edge_q  <= conf_edge_d;
         sel_s1_q     <= sel_s1_d;
         sel_s2_q     <= sel_s2_d;
         sel_prev_q   <= sel_prev_d;
         sel_edge_q   <= sel_edge_d;
         state_q      <= state_d;
         sel_zone_q   <= sel_zone_d;
         zone_latch_q <= zone_latch_d;
         anim_en_q    <= anim_en_d;
         hit_q        <= hit_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
      end
   end

   assign state      = state_q;
   assign sel_zone   = sel_zone_q;
   assign zone_latch = zone_latch_q;
   assign anim_en    = anim_en_q;
   assign hit        = hit_q;
   assign score      = score_q;
   assign lives      = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_round_sequencer : directed self-checking bench for round_sequencer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_round_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       confirm_btn = 1'b0;
   logic       select_btn = 1'b0;
   logic [1:0] target_zone = 2'd0;
   logic [2:0] state;
   logic [1:0] sel_zone;
   logic       zone_latch;
   logic       anim_en;
   logic       hit;
   logic [3:0] score;
   logic [1:0] lives;

   int n_cmp = 0;
   int n_err = 0;
   int zl_cnt = 0;

   round_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .confirm_btn (confirm_btn),
      .select_btn  (select_btn),
      .target_zone (target_zone),
      .state       (state),
      .sel_zone    (sel_zone),
      .zone_latch  (zone_latch),
      .anim_en     (anim_en),
      .hit         (hit),
      .score       (score),
      .lives       (lives)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n negedges, counting zone_latch pulses seen.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (zone_latch) zl_cnt++;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step(1);
         frame_tick = 1'b0;
         step(1);
      end
   endtask

   task automatic press(input logic c, input logic s);
      confirm_btn = c;
      select_btn  = s;
      step(6);
      confirm_btn = 1'b0;
      select_btn  = 1'b0;
      step(4);
   endtask

   task automatic to_guess();
      ticks(120 + 30 + 180);
   endtask

   initial begin
      step(3);
      check("rst_state", state, 0);
      reset = 1'b1;
      step(2);
      check("rst_sel", sel_zone, 0);
      check("rst_zl", zone_latch, 0);
      check("rst_anim", anim_en, 0);
      check("rst_hit", hit, 0);
      check("rst_score", score, 0);
      check("rst_lives", lives, 3);

      // Start and timed phase walk
      zl_cnt = 0;
      press(1'b1, 1'b0);
      check("start_state", state, 1);
      check("start_zl", zl_cnt, 1);
      ticks(119);
      check("show_119", state, 1);
      ticks(1);
      check("show_120", state, 2);
      ticks(29);
      check("hide_29", state, 2);
      ticks(1);
      check("hide_30", state, 3);
      check("shuf_anim", anim_en, 1);
      ticks(179);
      check("shuf_179", state, 3);
      ticks(1);
      check("guess_state", state, 4);
      check("guess_anim", anim_en, 0);

      // Two selects then a correct confirm
      target_zone = 2'd2;
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      check("sel_two", sel_zone, 2);
      press(1'b1, 1'b0);
      check("hit_state", state, 5);
      check("hit_hit", hit, 1);
      check("hit_score", score, 1);
      check("hit_lives", lives, 3);
      zl_cnt = 0;
      ticks(90);
      check("res_show", state, 1);
      check("res_zl", zl_cnt, 1);
      check("res_sel0", sel_zone, 0);

      // Guess timeout
      to_guess();
      check("guess2", state, 4);
      ticks(599);
      check("to_599", state, 4);
      ticks(1);
      check("to_state", state, 5);
      check("to_hit", hit, 0);
      check("to_lives", lives, 2);
      check("to_score", score, 1);
      zl_cnt = 0;
      ticks(90);
      check("to_show", state, 1);
      check("to_zl", zl_cnt, 1);

      // Select and confirm in the same cycle
      to_guess();
      target_zone = 2'd1;
      press(1'b0, 1'b1);
      check("sim_sel1", sel_zone, 1);
      press(1'b1, 1'b1);
      check("sim_state", state, 5);
      check("sim_hit", hit, 1);
      check("sim_sel", sel_zone, 1);
      check("sim_score", score, 2);
      ticks(90);

      // Confirm edge lands on the final timeout tick
      to_guess();
      target_zone = 2'd0;
      ticks(599);
      confirm_btn = 1'b1;
      step(3);
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      check("race_state", state, 5);
      check("race_hit", hit, 1);
      check("race_score", score, 3);
      check("race_lives", lives, 2);
      confirm_btn = 1'b0;
      step(4);
      ticks(90);

      // Misses until game over
      to_guess();
      target_zone = 2'd3;
      press(1'b1, 1'b0);
      check("miss1_hit", hit, 0);
      check("miss1_lives", lives, 1);
      ticks(90);
      to_guess();
      press(1'b1, 1'b0);
      check("miss2_lives", lives, 0);
      ticks(89);
      check("miss2_res", state, 5);
      ticks(1);
      check("over_state", state, 6);
      check("over_score", score, 3);
      press(1'b0, 1'b1);
      check("over_ignsel", state, 6);
      check("over_sel", sel_zone, 0);
      press(1'b1, 1'b0);
      check("over_idle", state, 0);
      check("idle_score", score, 3);

      // New game, score a point, reset mid-shuffle with button held
      press(1'b1, 1'b0);
      check("ng_state", state, 1);
      check("ng_score", score, 0);
      check("ng_lives", lives, 3);
      to_guess();
      target_zone = 2'd0;
      press(1'b1, 1'b0);
      check("ng_hit", score, 1);
      ticks(90);
      ticks(150);
      check("ng_shuf", state, 3);
      step(3);
      confirm_btn = 1'b1;
      reset = 1'b0;
      #1;
      check("ar_state", state, 0);
      check("ar_anim", anim_en, 0);
      check("ar_score", score, 0);
      check("ar_hit", hit, 0);
      check("ar_lives", lives, 3);
      check("ar_zl", zone_latch, 0);
      step(3);
      reset = 1'b1;
      zl_cnt = 0;
      step(10);
      check("held_state", state, 0);
      check("held_zl", zl_cnt, 0);
      confirm_btn = 1'b0;
      step(4);
      press(1'b1, 1'b0);
      check("repress", state, 1);
      check("repress_zl", zl_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
